sr_latch_stim: RTL

- Clocked stimulus generator and response checker for the gate-level NOR SR latch under delay-model evaluation.
- Drives the latch's `myset`/`myreset` inputs with programmable pulse trains.
- Samples the latch's `myoutQ`/`myoutNQ` outputs back through a 2-flop synchroniser, checks each settled state against the expected value, and counts mismatches.

---
 rtl/sr_latch_stim.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sr_latch_stim.sv
// Pulse-train driver and 2-flop-synchronised checker for a NOR SR latch; drives are registered and track FSM state with zero added latency.
// Check lands on the last GAP cycle (min 3, covers the sync delay); no backpressure, start is accepted only in IDLE and ignored otherwise.
module sr_latch_stim #(
  parameter int CNT_W = 16,
  parameter int NP_W  = 16
) (
  input  logic             myclk,
  input  logic             myrst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] gap_width,
  input  logic [NP_W-1:0]  num_pulses,
  input  logic             myoutQ,
  input  logic             myoutNQ,
  output logic             myset,
  output logic             myreset,
  output logic             busy,
  output logic             done,
  output logic [NP_W-1:0]  pulse_count,
  output logic [NP_W-1:0]  err_count,
  output logic [1:0]       last_q
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_pw;
  logic [CNT_W-1:0] r_gw;
  logic [NP_W-1:0]  r_np;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_exp;
  logic [1:0]       r_q_meta;
  logic [1:0]       r_q_sync;
  logic             r_set;
  logic             r_rst;
  logic             r_busy;
  logic             r_done;
  logic [NP_W-1:0]  r_pulse_count;
  logic [NP_W-1:0]  r_err_count;
  logic [1:0]       r_last_q;

  logic [CNT_W-1:0] w_pw_first;
  logic [CNT_W-1:0] w_pw_load;
  logic [CNT_W-1:0] w_gap_load;
  logic [1:0]       w_first_drv;
  logic [1:0]       w_next_drv;
  logic             w_mismatch;

  // Returns {set, reset}; for single-sided pulses this is also the expected {Q, NQ}.
  function automatic logic [1:0] f_drive(input logic [1:0] m, input logic k_odd);
    logic [1:0] d;
    case (m)
      2'b00:   d = k_odd ? 2'b01 : 2'b10;
      2'b01:   d = 2'b10;
      2'b10:   d = 2'b01;
      default: d = 2'b11;
    endcase
    return d;
  endfunction

  // Counters hold "cycles remaining minus one" so the terminal test is a compare to zero.
  assign w_pw_first  = (pulse_width == '0) ? '0 : pulse_width - CNT_W'(1);
  assign w_pw_load   = (r_pw == '0) ? '0 : r_pw - CNT_W'(1);
  assign w_gap_load  = (r_gw < CNT_W'(3)) ? CNT_W'(2) : r_gw - CNT_W'(1);
  assign w_first_drv = f_drive(mode, 1'b0);
  assign w_next_drv  = f_drive(r_mode, r_pulse_count[0]);
  assign w_mismatch  = (r_mode != 2'b11) && (r_q_sync != r_exp);

  always_ff @(posedge myclk) begin
    if (myrst) begin
      r_state       <= S_IDLE;
      r_mode        <= '0;
      r_pw          <= '0;
      r_gw          <= '0;
      r_np          <= '0;
      r_cnt         <= '0;
      r_exp         <= '0;
      r_q_meta      <= '0;
      r_q_sync      <= '0;
      r_set         <= 1'b0;
      r_rst         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pulse_count <= '0;
      r_err_count   <= '0;
      r_last_q      <= '0;
    end else begin
      r_q_meta <= {myoutQ, myoutNQ};
      r_q_sync <= r_q_meta;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode        <= mode;
            r_pw          <= pulse_width;
            r_gw          <= gap_width;
            r_np          <= num_pulses;
            r_pulse_count <= '0;
            r_err_count   <= '0;
            r_busy        <= 1'b1;
            if (num_pulses == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_PULSE;
              {r_set, r_rst} <= w_first_drv;
              r_exp   <= w_first_drv;
              r_cnt   <= w_pw_first;
            end
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) begin
            r_set         <= 1'b0;
            r_rst         <= 1'b0;
            r_pulse_count <= r_pulse_count + NP_W'(1);
            r_cnt         <= w_gap_load;
            r_state       <= S_GAP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_last_q <= r_q_sync;
            if (w_mismatch && (r_err_count != {NP_W{1'b1}})) begin
              r_err_count <= r_err_count + NP_W'(1);
            end
            if (r_pulse_count == r_np) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_PULSE;
              {r_set, r_rst} <= w_next_drv;
              r_exp   <= w_next_drv;
              r_cnt   <= w_pw_load;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign myset       = r_set;
  assign myreset     = r_rst;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pulse_count = r_pulse_count;
  assign err_count   = r_err_count;
  assign last_q      = r_last_q;

endmodule
